nco_clkgen: RTL and testbench

Multi-channel, runtime-programmable digital clock-enable generator. It sits downstream of the board PLL wrapper in the fast system clock domain. Each channel has its own frequency word and phase offset, and produces a clock-enable pulse and a square-wave reference. A lock/settle sequencer mirrors PLL "locked" semantics for downstream reset logic.

---
 rtl/nco_clkgen_pkg.sv | 19 +
 rtl/nco_channel.sv | 59 +++++
 rtl/nco_clkgen.sv | 111 +++++++++++
 tb/tb_nco_clkgen.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/nco_clkgen_pkg.sv
// Shared types and helpers for the nco_clkgen clock-enable generator.
package nco_clkgen_pkg;

  typedef enum logic {
    SETTLE = 1'b0,
    LOCKED = 1'b1
  } lock_state_e;

  localparam logic REG_INC   = 1'b0;
  localparam logic REG_PHASE = 1'b1;

  // Increment word giving f_out from f_clk with an acc_w-bit accumulator.
  function automatic logic [63:0] hz_to_inc(input logic [63:0] f_out,
                                            input logic [63:0] f_clk,
                                            input int unsigned acc_w);
    return (f_out << acc_w) / f_clk;
  endfunction

endpackage

// File: rtl/nco_channel.sv
// One NCO channel: increment/phase registers, phase accumulator, registered
// carry (clock enable) and MSB (square reference). Exposes its config
// registers when NCO_CLKGEN_READBACK_EN is defined.
module nco_channel
  import nco_clkgen_pkg::*;
#(
  parameter int               ACC_W      = 32,
  parameter logic [ACC_W-1:0] INIT_INC   = '0,
  parameter logic [ACC_W-1:0] INIT_PHASE = '0
) (
  input  logic             clk_i,
  input  logic             reset_n,
  input  logic             we_inc,
  input  logic             we_phase,
  input  logic             realign,
  input  logic [ACC_W-1:0] data,
`ifdef NCO_CLKGEN_READBACK_EN
  output logic [ACC_W-1:0] inc_q,
  output logic [ACC_W-1:0] phase_q,
`endif
  output logic             ce,
  output logic             clk_msb
);

`ifndef NCO_CLKGEN_READBACK_EN
  logic [ACC_W-1:0] inc_q;
  logic [ACC_W-1:0] phase_q;
`endif
  logic [ACC_W-1:0] acc_q;
  logic [ACC_W-1:0] phase_nxt;
  logic [ACC_W:0]   sum;

  // A phase write lands in the accumulator on the same realign edge.
  assign phase_nxt = we_phase ? data : phase_q;
  assign sum       = {1'b0, acc_q} + {1'b0, inc_q};

  always_ff @(posedge clk_i or negedge reset_n) begin
    if (!reset_n) begin
      inc_q   <= INIT_INC;
      phase_q <= INIT_PHASE;
      acc_q   <= INIT_PHASE;
      ce      <= 1'b0;
      clk_msb <= 1'b0;
    end else begin
      if (we_inc)   inc_q   <= data;
      if (we_phase) phase_q <= data;
      if (realign) begin
        acc_q   <= phase_nxt;
        ce      <= 1'b0;
        clk_msb <= phase_nxt[ACC_W-1];
      end else begin
        acc_q   <= sum[ACC_W-1:0];
        ce      <= sum[ACC_W];
        clk_msb <= sum[ACC_W-1];
      end
    end
  end

endmodule

// File: rtl/nco_clkgen.sv
// Multi-channel NCO clock-enable generator with lock/settle sequencer.
// Optional registered config readback: define NCO_CLKGEN_READBACK_EN.
module nco_clkgen
  import nco_clkgen_pkg::*;
#(
  parameter int                        CHANNELS    = 4,
  parameter int                        ACC_W       = 32,
  parameter int                        LOCK_CYCLES = 16,
  parameter logic [CHANNELS*ACC_W-1:0] INIT_INC    = '0,
  parameter logic [CHANNELS*ACC_W-1:0] INIT_PHASE  = '0,
  localparam int                       SEL_W       = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                clk_i,
  input  logic                reset_n,
  input  logic                sync_i,
  input  logic                cfg_we_i,
  input  logic [SEL_W-1:0]    cfg_sel_i,
  input  logic                cfg_phase_i,
  input  logic [ACC_W-1:0]    cfg_data_i,
  output logic [CHANNELS-1:0] ce_o,
  output logic [CHANNELS-1:0] clk_o,
`ifdef NCO_CLKGEN_READBACK_EN
  output logic [ACC_W-1:0]    cfg_rdata_o,
`endif
  output logic                locked_o
);

  localparam int               CNT_W    = (LOCK_CYCLES > 1) ? $clog2(LOCK_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LOCK_CYCLES - 1);
  localparam logic [SEL_W:0]   CH_LIM   = (SEL_W + 1)'(CHANNELS);

  logic              sel_ok;
  logic              we_ok;
  logic              realign;
  lock_state_e       state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

`ifdef NCO_CLKGEN_READBACK_EN
  logic [CHANNELS-1:0][ACC_W-1:0] inc_q;
  logic [CHANNELS-1:0][ACC_W-1:0] phase_q;
`endif

  assign sel_ok  = ({1'b0, cfg_sel_i} < CH_LIM);
  assign we_ok   = cfg_we_i && sel_ok;
  assign realign = sync_i || we_ok;

  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    logic hit;
    assign hit = we_ok && (cfg_sel_i == SEL_W'(i));

    nco_channel #(
      .ACC_W      (ACC_W),
      .INIT_INC   (INIT_INC[i*ACC_W +: ACC_W]),
      .INIT_PHASE (INIT_PHASE[i*ACC_W +: ACC_W])
    ) u_ch (
      .clk_i    (clk_i),
      .reset_n  (reset_n),
      .we_inc   (hit && (cfg_phase_i == REG_INC)),
      .we_phase (hit && (cfg_phase_i == REG_PHASE)),
      .realign  (realign),
      .data     (cfg_data_i),
`ifdef NCO_CLKGEN_READBACK_EN
      .inc_q    (inc_q[i]),
      .phase_q  (phase_q[i]),
`endif
      .ce       (ce_o[i]),
      .clk_msb  (clk_o[i])
    );
  end

  always_ff @(posedge clk_i or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= SETTLE;
      cnt_q    <= '0;
      locked_o <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      // Drop lock on the realign edge itself so downstream sees it a cycle sooner.
      locked_o <= (state_q == LOCKED) && !realign;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      SETTLE: begin
        if (realign)                cnt_d   = '0;
        else if (cnt_q == CNT_LAST) state_d = LOCKED;
        else                        cnt_d   = cnt_q + 1'b1;
      end
      LOCKED: begin
        if (realign) begin
          state_d = SETTLE;
          cnt_d   = '0;
        end
      end
    endcase
  end

`ifdef NCO_CLKGEN_READBACK_EN
  always_ff @(posedge clk_i or negedge reset_n) begin
    if (!reset_n)                     cfg_rdata_o <= '0;
    else if (!sel_ok)                 cfg_rdata_o <= '0;
    else if (cfg_phase_i == REG_PHASE) cfg_rdata_o <= phase_q[cfg_sel_i];
    else                              cfg_rdata_o <= inc_q[cfg_sel_i];
  end
`endif

endmodule

// File: tb/tb_nco_clkgen.sv
// Directed bench for nco_clkgen (5 channels so that sel=5 is out of range).
module tb_nco_clkgen;
  import nco_clkgen_pkg::*;

  localparam int CH = 5;
  localparam int AW = 32;
  localparam logic [AW-1:0] INC0 = AW'(hz_to_inc(64'd25_000_000, 64'd100_000_000, AW));

  logic          clk_i = 1'b0;
  logic          reset_n = 1'b0;
  logic          sync_i = 1'b0;
  logic          cfg_we_i = 1'b0;
  logic [2:0]    cfg_sel_i = '0;
  logic          cfg_phase_i = 1'b0;
  logic [AW-1:0] cfg_data_i = '0;
  logic [CH-1:0] ce_o;
  logic [CH-1:0] clk_o;
  logic          locked_o;
`ifdef NCO_CLKGEN_READBACK_EN
  logic [AW-1:0] cfg_rdata_o;
`endif

  int errors = 0;
  int checks = 0;

  nco_clkgen #(
    .CHANNELS    (CH),
    .ACC_W       (AW),
    .LOCK_CYCLES (16),
    .INIT_INC    ({32'h0, 32'h0, 32'h0, 32'h0, INC0}),
    .INIT_PHASE  ({32'h0, 32'h0, 32'h0, 32'h1234_5678, 32'h0})
  ) dut (
    .clk_i       (clk_i),
    .reset_n     (reset_n),
    .sync_i      (sync_i),
    .cfg_we_i    (cfg_we_i),
    .cfg_sel_i   (cfg_sel_i),
    .cfg_phase_i (cfg_phase_i),
    .cfg_data_i  (cfg_data_i),
    .ce_o        (ce_o),
    .clk_o       (clk_o),
`ifdef NCO_CLKGEN_READBACK_EN
    .cfg_rdata_o (cfg_rdata_o),
`endif
    .locked_o    (locked_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic wr(input logic [2:0] sel, input logic ph, input logic [AW-1:0] d);
    cfg_we_i = 1'b1; cfg_sel_i = sel; cfg_phase_i = ph; cfg_data_i = d;
    step();
    cfg_we_i = 1'b0;
  endtask

  initial begin
    logic [CH-1:0] e;
    int cnt, first, prev, bad;

    // Reset state, then release mid-cycle
    #2;
    chk("rst_ce", ce_o, 0);
    chk("rst_clk", clk_o, 0);
    chk("rst_lock", locked_o, 0);
    step(); #3;
    reset_n = 1'b1;
    for (int j = 1; j <= 20; j++) begin
      step();
      e = '0; e[0] = (j % 4 == 0);
      chk($sformatf("a_ce%0d", j), ce_o, e);
      e = '0; e[0] = (j % 4 >= 2);
      chk($sformatf("a_clk%0d", j), clk_o, e);
      chk($sformatf("a_lock%0d", j), locked_o, (j >= 17));
    end

    // ch1 inc then phase: ch1 leads ch0 by 2 cycles
    wr(3'd1, REG_INC, 32'h4000_0000);
    chk("b_w1_lock", locked_o, 0);
    chk("b_w1_ce", ce_o, 0);
    wr(3'd1, REG_PHASE, 32'h8000_0000);
    chk("b_w2_ce", ce_o, 0);
    chk("b_w2_clk", clk_o, 5'b00010);
    for (int j = 1; j <= 20; j++) begin
      step();
      e = '0; e[0] = (j % 4 == 0); e[1] = (j % 4 == 2);
      chk($sformatf("b_ce%0d", j), ce_o, e);
      chk($sformatf("b_lock%0d", j), locked_o, (j >= 17));
    end

    // ch2 inc = 5555_5555: carries at n = 4, 7, ..., 298
    wr(3'd2, REG_INC, 32'h5555_5555);
    cnt = 0; first = 0; prev = 0; bad = 0;
    for (int n = 1; n <= 300; n++) begin
      step();
      if (ce_o[2]) begin
        cnt++;
        if (first == 0) first = n;
        if (prev != 0 && (n - prev) != 3) bad++;
        prev = n;
      end
    end
    chk("c_count", cnt, 99);
    chk("c_first", first, 4);
    chk("c_spacing", bad, 0);

    // sync coincident with ch0 phase write: one realign
    sync_i = 1'b1;
    wr(3'd0, REG_PHASE, 32'hC000_0000);
    sync_i = 1'b0;
    chk("d_ce", ce_o, 0);
    chk("d_clk", clk_o, 5'b00011);
    chk("d_lock", locked_o, 0);
    step();
    chk("d_ce1", ce_o, 5'b00001);
    for (int j = 2; j <= 21; j++) begin
      step();
      if (j == 16 || j == 17) chk($sformatf("d_lock%0d", j), locked_o, (j >= 17));
    end

    // Out-of-range write: no realign, ch0 rhythm continues
    wr(3'd5, REG_PHASE, 32'h0);
    chk("e_lock22", locked_o, 1);
    chk("e_ce22", ce_o[0], 0);
    step();
    chk("e_lock23", locked_o, 1);
    chk("e_ce23", ce_o[0], 0);
    chk("e_ce3", ce_o[3], 0);
    chk("e_clk3", clk_o[3], 0);
    step(); step();
    chk("e_ce25", ce_o[0], 1);

    // Frozen ch3 with MSB set; ch4 inc all-ones
    wr(3'd3, REG_PHASE, 32'h8000_0000);
    chk("f_clk3", clk_o[3], 1);
    chk("f_lock", locked_o, 0);
    wr(3'd4, REG_INC, 32'hFFFF_FFFF);
    step();
    chk("f_ce4_1", ce_o[4], 0);
    step();
    chk("f_ce4_2", ce_o[4], 1);
    step();
    chk("f_ce4_3", ce_o[4], 1);
    chk("f_ce3", ce_o[3], 0);
    chk("f_clk3h", clk_o[3], 1);

    // sync held high: pinned at phase, no lock
    sync_i = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      step();
      chk($sformatf("g_ce%0d", k), ce_o, 0);
      chk($sformatf("g_clk%0d", k), clk_o, 5'b01011);
      chk($sformatf("g_lock%0d", k), locked_o, 0);
    end
    sync_i = 1'b0;
    step(); step(); step();

    // Async reset mid-cycle during settle
    #3;
    reset_n = 1'b0;
    #1;
    chk("h_ce", ce_o, 0);
    chk("h_clk", clk_o, 0);
    chk("h_lock", locked_o, 0);
    cfg_sel_i = 3'd1; cfg_phase_i = REG_PHASE;
    #1;
    reset_n = 1'b1;
    for (int j = 1; j <= 4; j++) begin
      step();
`ifdef NCO_CLKGEN_READBACK_EN
      if (j == 1) chk("h_rdata", cfg_rdata_o, 32'h1234_5678);
`endif
      e = '0; e[0] = (j == 4);
      chk($sformatf("h_ce%0d", j), ce_o, e);
      e = '0; e[0] = (j % 4 >= 2);
      chk($sformatf("h_clk%0d", j), clk_o, e);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
